// File: rtl/spatial_offset_reader_if.sv
// -----------------------------------------------------------------------------
// spatial_offset_reader_if
// Bundles the frame-buffer read bus and the outgoing pixel stream of the
// spatial offset reader.
//   mem_rd_en   : read strobe toward the frame buffer
//   mem_addr    : row-major word address of the read
//   mem_rd_data : read data, valid the cycle after mem_rd_en
//   pix_data    : output pixel
//   pix_valid   : pixel and markers valid
//   pix_ready   : downstream accept
//   pix_sof     : first pixel of frame
//   pix_eol     : last pixel of line
//   pix_eof     : last pixel of frame
// master = reader side, slave = memory / pixel sink side.
// -----------------------------------------------------------------------------
interface spatial_offset_reader_if;
   logic        mem_rd_en;
   logic [19:0] mem_addr;
   logic [7:0]  mem_rd_data;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;
   logic        pix_eof;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rd_data,
      output pix_data,
      output pix_valid,
      input  pix_ready,
      output pix_sof,
      output pix_eol,
      output pix_eof
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rd_data,
      input  pix_data,
      input  pix_valid,
      output pix_ready,
      input  pix_sof,
      input  pix_eol,
      input  pix_eof
   );
endinterface

// File: rtl/spatial_offset_reader.sv
// -----------------------------------------------------------------------------
// spatial_offset_reader
// Streams one SENSOR_WIDTH x SENSOR_HEIGHT output frame per start request.
// Output pixel (x,y) is taken from frame-buffer position
// (x+HORIZONTAL_OFFSET, y+VERTICAL_OFFSET); positions outside the frame
// produce FILL_VALUE without a memory read.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : one-cycle frame request, honoured only when idle
//   busy  : high from accepted start until done
//   done  : one-cycle pulse after the final pixel transfers
//   bus   : frame-buffer read bus and pixel stream (master side)
// -----------------------------------------------------------------------------
module spatial_offset_reader #(
   parameter int          SENSOR_WIDTH      = 960,
   parameter int          SENSOR_HEIGHT     = 540,
   parameter int          HORIZONTAL_OFFSET = 50,
   parameter int          VERTICAL_OFFSET   = 30,
   parameter logic [7:0]  FILL_VALUE        = 8'h00
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   spatial_offset_reader_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eol;
      logic       eof;
   } entry_t;

   state_t      state;
   state_t      state_next;
   logic        done_q;

   logic [11:0] x_cnt;
   logic [11:0] y_cnt;

   logic [11:0] src_x;
   logic [11:0] src_y;
   logic        in_frame;
   logic        pos_sof;
   logic        pos_eol;
   logic        pos_last;
   logic [19:0] rd_addr;

   entry_t      slot0;
   entry_t      slot1;
   entry_t      slot0_next;
   entry_t      slot1_next;
   logic [1:0]  fifo_count;
   logic [1:0]  count_next;

   logic        inflight;
   logic [2:0]  inflight_mark;

   logic        pop;
   logic        issue;
   logic        rd_issue;
   logic        fill_issue;
   logic        eof_pop;
   logic [2:0]  committed;
   entry_t      rd_entry;
   entry_t      fill_entry;

   // Source position of the current raster position; 12-bit sums so large
   // offsets push positions out of the frame instead of wrapping back in.
   assign src_x    = x_cnt + 12'(HORIZONTAL_OFFSET);
   assign src_y    = y_cnt + 12'(VERTICAL_OFFSET);
   assign in_frame = (src_x < 12'(SENSOR_WIDTH)) && (src_y < 12'(SENSOR_HEIGHT));
   assign pos_sof  = (x_cnt == 12'd0) && (y_cnt == 12'd0);
   assign pos_eol  = (x_cnt == 12'(SENSOR_WIDTH - 1));
   assign pos_last = pos_eol && (y_cnt == 12'(SENSOR_HEIGHT - 1));
   assign rd_addr  = 20'(src_y) * 20'(SENSOR_WIDTH) + 20'(src_x);

   // A position may be issued only if the FIFO will have room for it once this
   // cycle's pop is accounted for, counting a read still on its way back.
   // Including the pop keeps throughput at one pixel per clock.
   assign pop        = (fifo_count != 2'd0) && bus.pix_ready;
   assign committed  = 3'(fifo_count) - 3'(pop) + 3'(inflight);
   assign issue      = (state == RUN) && (committed < 3'd2);
   assign rd_issue   = issue && in_frame;
   assign fill_issue = issue && !in_frame;
   assign eof_pop    = pop && slot0.eof;

   assign rd_entry   = '{data: bus.mem_rd_data, sof: inflight_mark[2],
                         eol: inflight_mark[1], eof: inflight_mark[0]};
   assign fill_entry = '{data: FILL_VALUE, sof: pos_sof, eol: pos_eol, eof: pos_last};

   // FSM state register; done is registered so it lands the cycle after the
   // final transfer, together with busy falling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= (state == DRAIN) && eof_pop;
      end
   end

   // FSM next state; a start coinciding with the done pulse is dropped.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start && !done_q) state_next = RUN;
         RUN:     if (issue && pos_last) state_next = DRAIN;
         DRAIN:   if (eof_pop) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs; reads only happen while issuing in RUN, address idles at 0.
   always_comb begin
      busy          = (state != IDLE);
      done          = done_q;
      bus.mem_rd_en = rd_issue;
      bus.mem_addr  = rd_issue ? rd_addr : 20'd0;
   end

   // Raster counters, x fastest; parked at (0,0) whenever idle so an aborted
   // or finished frame always restarts at the origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= 12'd0;
         y_cnt <= 12'd0;
      end else if (state == IDLE) begin
         x_cnt <= 12'd0;
         y_cnt <= 12'd0;
      end else if (issue) begin
         if (pos_eol) begin
            x_cnt <= 12'd0;
            y_cnt <= y_cnt + 12'd1;
         end else begin
            x_cnt <= x_cnt + 12'd1;
         end
      end
   end

   // Read tracking: the markers of an issued read travel alongside it until
   // its data returns one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight      <= 1'b0;
         inflight_mark <= 3'b000;
      end else begin
         inflight      <= rd_issue;
         inflight_mark <= {pos_sof, pos_eol, pos_last};
      end
   end

   // FIFO update: pop first, then append returning read data, then a fill
   // issued this cycle. The returning read is always older than the current
   // position, so this order preserves raster order when both arrive at once.
   always_comb begin
      slot0_next = slot0;
      slot1_next = slot1;
      count_next = fifo_count;
      if (pop) begin
         slot0_next = slot1;
         count_next = fifo_count - 2'd1;
      end
      if (inflight) begin
         if (count_next == 2'd0) slot0_next = rd_entry;
         else                    slot1_next = rd_entry;
         count_next = count_next + 2'd1;
      end
      if (fill_issue) begin
         if (count_next == 2'd0) slot0_next = fill_entry;
         else                    slot1_next = fill_entry;
         count_next = count_next + 2'd1;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0      <= '0;
         slot1      <= '0;
         fifo_count <= 2'd0;
      end else begin
         slot0      <= slot0_next;
         slot1      <= slot1_next;
         fifo_count <= count_next;
      end
   end

   // Pixel stream is the FIFO head; markers are qualified by valid.
   assign bus.pix_valid = (fifo_count != 2'd0);
   assign bus.pix_data  = slot0.data;
   assign bus.pix_sof   = bus.pix_valid && slot0.sof;
   assign bus.pix_eol   = bus.pix_valid && slot0.eol;
   assign bus.pix_eof   = bus.pix_valid && slot0.eof;

endmodule

// File: tb/tb_spatial_offset_reader.sv
// -----------------------------------------------------------------------------
// tb_spatial_offset_reader
// Scoreboard bench for spatial_offset_reader on a small frame so whole frames
// fit comfortably in simulation. A reference raster model fills queues of
// expected read addresses and pixels; a monitor compares what the DUT emits.
// -----------------------------------------------------------------------------
module tb_spatial_offset_reader;

   localparam int         W          = 12;
   localparam int         H          = 8;
   localparam int         HOFF       = 5;
   localparam int         VOFF       = 3;
   localparam logic [7:0] FILL       = 8'h5A;
   localparam int         NPIX       = W * H;
   localparam int         EXP_READS  = (W - HOFF) * (H - VOFF);
   localparam int         FIRST_ADDR = VOFF * W + HOFF;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy;
   logic done;

   spatial_offset_reader_if bus ();

   spatial_offset_reader #(
      .SENSOR_WIDTH      (W),
      .SENSOR_HEIGHT     (H),
      .HORIZONTAL_OFFSET (HOFF),
      .VERTICAL_OFFSET   (VOFF),
      .FILL_VALUE        (FILL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [NPIX];
   logic [10:0] exp_pix [$];
   logic [19:0] exp_addr [$];
   logic [10:0] pix_vec;
   int          total;
   int          bad;
   int          xfer_count;
   int          rd_count;
   int          done_count;
   logic        ready_random;
   logic        eof_prev;
   logic        stalled_prev;
   logic [10:0] held_prev;

   assign pix_vec = {bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof};

   // Frame buffer: one-cycle read latency, garbage on idle cycles.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[int'(bus.mem_addr) % NPIX];
      else               bus.mem_rd_data <= 8'($urandom);
   end

   // Downstream sink: always ready, or a 50% random accept pattern.
   always @(posedge clk) begin
      #1;
      bus.pix_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      total++;
      bad++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   // Reference raster: every output position in order, its source position,
   // and whether it needs a read.
   task automatic build_frame();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int         sx = x + HOFF;
            int         sy = y + VOFF;
            logic [7:0] d;
            logic       sof = (x == 0) && (y == 0);
            logic       eol = (x == W - 1);
            logic       eof = eol && (y == H - 1);
            if (sx < W && sy < H) begin
               exp_addr.push_back(20'(sy * W + sx));
               d = mem[sy * W + sx];
            end else begin
               d = FILL;
            end
            exp_pix.push_back({d, sof, eol, eof});
         end
      end
   endtask

   // Monitor: reads, transfers, hold-while-stalled and done placement.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled_prev = 1'b0;
         eof_prev     = 1'b0;
      end else begin
         if (stalled_prev)
            check_output("stall_hold", {bus.pix_valid, pix_vec}, {1'b1, held_prev});
         if (bus.mem_rd_en) begin
            rd_count++;
            if (exp_addr.size() == 0) fail_now("extra_read", $sformatf("got addr %0d, expected no read", bus.mem_addr));
            else check_output("rd_addr", bus.mem_addr, exp_addr.pop_front());
         end
         if (done) begin
            done_count++;
            check_output("done_after_eof_busy_low", {eof_prev, busy}, 2'b10);
         end
         eof_prev = 1'b0;
         if (bus.pix_valid && bus.pix_ready) begin
            xfer_count++;
            if (exp_pix.size() == 0) fail_now("extra_pixel", $sformatf("got %0h, expected nothing", pix_vec));
            else check_output("pixel", pix_vec, exp_pix.pop_front());
            eof_prev = bus.pix_eof;
         end
         stalled_prev = bus.pix_valid && !bus.pix_ready;
         held_prev    = pix_vec;
      end
   end

   task automatic check_reset_outputs(input string name);
      check_output(name, {busy, done, bus.mem_rd_en, bus.mem_addr, bus.pix_valid,
                          bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.pix_data}, 64'd0);
   endtask

   // Issues a start; returns at #1 after the edge that samples it.
   task automatic apply_stimulus();
      exp_pix.delete();
      exp_addr.delete();
      xfer_count = 0;
      rd_count   = 0;
      done_count = 0;
      build_frame();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits at negedges for done; edges = negedges waited before done, -1 on timeout.
   task automatic wait_done(input int budget, output int edges);
      edges = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            edges = i;
            break;
         end
         @(posedge clk);
      end
      if (edges < 0) fail_now("done_timeout", $sformatf("got no done within %0d cycles", budget));
   endtask

   task automatic end_frame_checks(input string tag);
      @(posedge clk);
      #1;
      check_output({tag, "_xfers"}, xfer_count, NPIX);
      check_output({tag, "_reads"}, rd_count, EXP_READS);
      check_output({tag, "_done_pulses"}, done_count, 1);
      check_output({tag, "_pix_left"}, exp_pix.size(), 0);
      check_output({tag, "_busy_low"}, busy, 0);
   endtask

   // Full-speed frame with first-pixel latency and throughput checks.
   task automatic run_fast_frame(input string tag);
      int edges;
      ready_random = 1'b0;
      apply_stimulus();
      check_output({tag, "_busy"}, busy, 1);
      check_output({tag, "_first_rd_en"}, bus.mem_rd_en, 1);
      check_output({tag, "_first_addr"}, bus.mem_addr, FIRST_ADDR);
      check_output({tag, "_valid_e0"}, bus.pix_valid, 0);
      @(posedge clk);
      #1 check_output({tag, "_valid_e1"}, bus.pix_valid, 0);
      @(posedge clk);
      #1 check_output({tag, "_first_valid_sof"}, {bus.pix_valid, bus.pix_sof}, 2'b11);
      wait_done(4 * NPIX, edges);
      if (edges >= 0) check_output({tag, "_throughput"}, (edges + 2) <= NPIX + 4, 1);
      end_frame_checks(tag);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int edges;
      total         = 0;
      bad           = 0;
      xfer_count    = 0;
      rd_count      = 0;
      done_count    = 0;
      ready_random  = 1'b0;
      stalled_prev  = 1'b0;
      eof_prev      = 1'b0;
      held_prev     = '0;
      rst_n         = 1'b0;
      start         = 1'b0;
      bus.pix_ready = 1'b1;
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset_state");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] frame 1: full speed");
      run_fast_frame("f1");

      $display("[TB] frame 2: random backpressure, starts while busy and on done");
      ready_random = 1'b1;
      apply_stimulus();
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      wait_done(8 * NPIX, edges);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      end_frame_checks("f2");
      check_output("f2_no_restart_reads", rd_count, EXP_READS);

      $display("[TB] frame 3: reset mid-frame");
      apply_stimulus();
      for (int i = 0; i < 4000 && xfer_count < 40; i++) @(posedge clk);
      if (xfer_count < 40) fail_now("abort_point", $sformatf("got %0d transfers, expected 40", xfer_count));
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_frame");
      exp_pix.delete();
      exp_addr.delete();
      done_count = 0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset_held");
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 check_output("abort_no_done", done_count, 0);
      check_output("abort_idle", {busy, bus.pix_valid, bus.mem_rd_en}, 3'b000);

      $display("[TB] frame 4: restart after abort");
      run_fast_frame("f4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spatial_offset_reader.md
SPATIAL_OFFSET_READER -- requirements
Module: spatial_offset_reader

Interface
REQ-001 Parameter SENSOR_WIDTH, default 960: active pixels per line of the source frame buffer.
REQ-002 Parameter SENSOR_HEIGHT, default 540: active lines of the source frame buffer.
REQ-003 Parameter HORIZONTAL_OFFSET, default 50: column offset added to output x to form source x.
REQ-004 Parameter VERTICAL_OFFSET, default 30: row offset added to output y to form source y.
REQ-005 Parameter FILL_VALUE, default 8'h00: pixel value emitted when the source position is outside the frame.
REQ-006 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 Port start, input, 1: single-cycle request to stream one frame.
REQ-009 Port busy, output, 1: high from the accepted start until done.
REQ-010 Port done, output, 1: one-cycle pulse when the last pixel of a frame is accepted.
REQ-011 Port mem_rd_en, output, 1: frame-buffer read strobe.
REQ-012 Port mem_addr, output, 20: frame-buffer word address, row-major.
REQ-013 Port mem_rd_data, input, 8: read data, valid exactly one cycle after mem_rd_en.
REQ-014 Port pix_data, output, 8: output pixel.
REQ-015 Port pix_valid, output, 1: pix_data and the marker outputs are valid.
REQ-016 Port pix_ready, input, 1: downstream accept; transfer occurs when pix_valid and pix_ready are both high.
REQ-017 Port pix_sof / pix_eol / pix_eof, output, 1 each: first pixel of frame / last pixel of line / last pixel of frame.

Function
REQ-018 Output raster is SENSOR_WIDTH x SENSOR_HEIGHT, x fastest, starting at (0,0).
REQ-019 Source position: sx = x + HORIZONTAL_OFFSET, sy = y + VERTICAL_OFFSET, computed at 12-bit width with no wrap.
REQ-020 If sx < SENSOR_WIDTH and sy < SENSOR_HEIGHT: issue a read with mem_addr = sy*SENSOR_WIDTH + sx; otherwise emit FILL_VALUE and issue no read.
REQ-021 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start. RUN->DRAIN after the last raster position is issued. DRAIN->IDLE when the last pixel transfers.
REQ-022 start is ignored unless the FSM is in IDLE.
REQ-023 A 2-entry output FIFO holds pixel data and markers.
REQ-024 A position (read or fill) is issued only when FIFO occupancy + in-flight reads < 2, so no data is lost under backpressure.
REQ-025 Fill positions enter the FIFO on the cycle they are issued; read data enters the FIFO one cycle after mem_rd_en; FIFO ordering equals raster order.
REQ-026 Minimum latency from start to first pix_valid is 2 cycles for a read position; sustained throughput is 1 pixel/clk while pix_ready is held high.
REQ-027 pix_data and markers are held stable while pix_valid=1 and pix_ready=0.
REQ-028 pix_eol is asserted at x = SENSOR_WIDTH-1; pix_eof and pix_eol are both asserted at the final pixel; pix_sof is asserted at (0,0) only.
REQ-029 done pulses on the cycle after the eof transfer, and busy falls on that same cycle.
REQ-030 mem_rd_en is low whenever the FSM is in IDLE or DRAIN.
REQ-031 A start arriving on the same cycle as the done pulse is ignored.

Reset
REQ-032 While rst_n=0: FSM = IDLE; counters = 0; FIFO empty; in-flight flag cleared; busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof = 0; mem_addr = 0; pix_data = 0.
REQ-033 Reset asserted mid-frame aborts the frame: no done pulse, and any pending read data is discarded. The next start begins again at (0,0).

Verification
REQ-034 Default parameters, start, pix_ready=1 -> first read at mem_addr 28850 (30*960+50); first transfer has pix_sof=1 and data = mem[28850].
REQ-035 Full frame, pix_ready=1 -> exactly 518400 transfers and exactly 464100 reads (910*510); transfers with x>=910 or y>=510 carry 8'h00; done pulses once.
REQ-036 Output (909,509) -> mem_addr 518399. Output (959,539) -> fill value, with pix_eol=1 and pix_eof=1.
REQ-037 Random pix_ready (50% duty) -> the transferred stream matches the reference raster model bit-exactly; no pixel is dropped or duplicated; pix_data is stable while stalled.
REQ-038 Assert rst_n=0 at pixel 1000, release, then start -> all outputs are 0 during reset; the new frame starts with pix_sof at mem_addr 28850; no done pulse from the aborted frame.
REQ-039 Start pulses while busy and on the done cycle -> ignored; exactly one frame is streamed.
